led_matrix_scan_ctrl: RTL and testbench
=======================================

// Module: led_matrix_scan_ctrl
// PURPOSE
//  Scan sequencer for the LED matrix panel inside LedMatrixTop. Reads pixels from a frame-buffer read port.
//  Shifts one bit plane of one row into the panel, latches it, then lights it for a binary-weighted
//  time (BCM). Walks all planes of all rows and wraps forever.
//  Sits between the frame buffer and the active-low LED_R_/LED_G_/LED_B_ panel pins.
// PARAMETERS
//  COLS        32  pixels per row
//  ROWS        16  scanned rows
//  BPC         4   bits per colour channel (bit planes), >=1
//  BASE_TICKS  8   display cycles of plane 0; plane p lights for BASE_TICKS<<p cycles, >=1
// PORTS
//  clk          in   1                  clock
//  reset        in   1                  async, active-high
//  enable       in   1                  run scanning
//  mem_rd_en    out  1                  frame-buffer read strobe
//  mem_rd_addr  out  clog2(ROWS*COLS)   row*COLS+col
//  mem_rd_data  in   3*BPC              {r,g,b} each BPC bits, valid 1 cycle after mem_rd_en
//  led_r_       out  1                  red data, active-low (0 = on)
//  led_g_       out  1                  green data, active-low
//  led_b_       out  1                  blue data, active-low
//  pnl_clk      out  1                  panel shift clock, data sampled on rising edge
//  pnl_lat      out  1                  latch pulse
//  pnl_oe_      out  1                  output enable, active-low (1 = blank)
//  pnl_row      out  clog2(ROWS)        row address
//  frame_done   out  1                  1-cycle pulse after last DISPLAY of last row
// BEHAVIOUR
//  Reset values:
//   - led_*_=1, pnl_clk=0, pnl_lat=0, pnl_oe_=1, pnl_row=0.
//   - mem_rd_en=0, mem_rd_addr=0, frame_done=0.
//   - FSM=IDLE, row=0, plane=0.
//  Reset asserted mid-operation: all outputs return to reset values immediately (async).
//  FSM: IDLE -> SHIFT -> LATCH -> DISPLAY -> (next plane/row) SHIFT | IDLE.
//  IDLE: pnl_oe_=1. Leaves on the first cycle enable=1.
//  SHIFT: exactly 2*COLS+2 cycles, k=0..2*COLS+1. For column c:
//   - cycle 2c: mem_rd_en=1, addr=row*COLS+c.
//   - cycle 2c+1: data valid; register bit[plane] of each channel.
//   - cycle 2c+2: led_*_=~bit, pnl_clk=0.
//   - cycle 2c+3: pnl_clk=1, led_*_ held.
//   - mem_rd_en=0 on odd cycles and on the last 2 cycles.
//  LATCH: 2 cycles.
//   - Cycle 0: pnl_lat=1, and pnl_row<=row when plane==0.
//   - Cycle 1: pnl_lat=0.
//  DISPLAY: exactly BASE_TICKS<<plane cycles with pnl_oe_=0. The only state with OE low.
//   - pnl_oe_ and pnl_lat are never both active in the same cycle.
//  End of DISPLAY:
//   - plane++ if plane<BPC-1.
//   - Otherwise plane=0 and row++ (wrap at ROWS-1 -> 0).
//   - On wrap, frame_done=1 for the first cycle of the next state.
//  Cycles per (row, plane): 2*COLS+4+(BASE_TICKS<<plane).
//  Frame = ROWS*(BPC*(2*COLS+4)+BASE_TICKS*(2^BPC-1)). Defaults: 392/row, 6272/frame.
//  enable is checked only in IDLE and on the last DISPLAY cycle.
//   - enable=0 mid-SHIFT/LATCH/DISPLAY: the current plane completes normally.
//   - Then IDLE, blanked; row/plane reset to 0; next start is row 0, plane 0.
//  Outside SHIFT: pnl_clk=0; led_*_ hold their last value.
//  Plane time counter width: BPC-1+clog2(BASE_TICKS+1). No overflow allowed.
// STRUCTURE
//  Package led_matrix_pkg:
//   - scan_state_t enum {IDLE,SHIFT,LATCH,DISPLAY}.
//   - Default COLS/ROWS/BPC constants.
//   - clog2 helper.
//  Sub-module led_bcm_timer: loadable down-counter.
//   - Loads BASE_TICKS<<plane.
//   - Asserts done on its last count.
//  Everything else (FSM, column/row/plane counters, output registers) stays in this module.
// TESTING
//  1 Reset, enable=0 for 50 cycles -> pnl_oe_=1, led_*_=1, mem_rd_en=0 throughout.
//  2 enable=1, memory pixel (r,g,b)=(0xF,0x0,0x5) at every addr ->
//    - plane0 shifts led_r_=0, led_g_=1, led_b_=0.
//    - plane1 shifts led_b_=1.
//    - Exactly 32 pnl_clk rising edges per SHIFT.
//  3 Count pnl_oe_=0 cycles per plane on row 0 -> 8, 16, 32, 64.
//    - Row 1 appears on pnl_row at the first LATCH after cycle 392.
//  4 Free-run -> frame_done pulses every 6272 cycles.
//    - Addresses cover 0..511, each read BPC times per frame.
//  5 Drop enable at DISPLAY of row 3, plane 2 ->
//    - 32 OE cycles finish, then IDLE with pnl_oe_=1.
//    - Re-enable restarts at addr 0, pnl_row=0.
//  6 Assert reset mid-SHIFT -> same-cycle reset values; no pnl_lat, no OE-low afterwards until re-enabled.

Source files
------------

// File: rtl/led_matrix_pkg.sv
// Shared types, default geometry and a constant-evaluable log2 helper for the LED matrix scanner.
package led_matrix_pkg;

  typedef enum logic [1:0] {StIdle, StShift, StLatch, StDisplay} scan_state_t;

  localparam int unsigned DefCols      = 32;
  localparam int unsigned DefRows      = 16;
  localparam int unsigned DefBpc       = 4;
  localparam int unsigned DefBaseTicks = 8;

  // Ceiling log2, never below 1 so it can size a vector directly.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(v)) r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/led_bcm_timer.sv
// Loadable down-counter that times one binary-weighted display slot.
module led_bcm_timer #(
  parameter int unsigned Width = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = en_i && (cnt_q == Width'(1));

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// BCM scan sequencer: shifts one bit plane of one row into the panel, latches it,
// then lights it for BASE_TICKS<<plane cycles, walking all planes and rows forever.
module led_matrix_scan_ctrl
  import led_matrix_pkg::*;
#(
  parameter int unsigned COLS       = DefCols,
  parameter int unsigned ROWS       = DefRows,
  parameter int unsigned BPC        = DefBpc,
  parameter int unsigned BASE_TICKS = DefBaseTicks
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  output logic                         mem_rd_en,
  output logic [clog2(ROWS*COLS)-1:0]  mem_rd_addr,
  input  logic [3*BPC-1:0]             mem_rd_data,
  output logic                         led_r_,
  output logic                         led_g_,
  output logic                         led_b_,
  output logic                         pnl_clk,
  output logic                         pnl_lat,
  output logic                         pnl_oe_,
  output logic [clog2(ROWS)-1:0]       pnl_row,
  output logic                         frame_done
);

  localparam int unsigned AW = clog2(ROWS * COLS);
  localparam int unsigned RW = clog2(ROWS);
  localparam int unsigned KW = clog2(2 * COLS + 2);
  localparam int unsigned PW = clog2(BPC);
  localparam int unsigned TW = BPC - 1 + clog2(BASE_TICKS + 1);

  scan_state_t   state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [RW-1:0] row_q, row_d;
  logic [PW-1:0] plane_q, plane_d;
  logic [2:0]    led_q, led_d;
  logic          pnl_clk_q, pnl_clk_d;
  logic [RW-1:0] pnl_row_q, pnl_row_d;
  logic          frame_done_q, frame_done_d;
  logic          tmr_done;

  logic [BPC-1:0] pix_r, pix_g, pix_b;
  assign pix_r = mem_rd_data[3*BPC-1:2*BPC];
  assign pix_g = mem_rd_data[2*BPC-1:BPC];
  assign pix_b = mem_rd_data[BPC-1:0];

  led_bcm_timer #(
    .Width (TW)
  ) u_timer (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     ((state_q == StLatch) && (k_q == KW'(1))),
    .load_val_i (TW'(BASE_TICKS) << plane_q),
    .en_i       (state_q == StDisplay),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    row_d        = row_q;
    plane_d      = plane_q;
    led_d        = led_q;
    pnl_row_d    = pnl_row_q;
    pnl_clk_d    = 1'b0;
    frame_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StShift;
          k_d     = '0;
        end
      end
      StShift: begin
        k_d = k_q + KW'(1);
        // Read data is valid on odd cycles; it drives the pins for the next two.
        if (k_q[0] && (k_q < KW'(2 * COLS))) begin
          led_d = ~{pix_r[plane_q], pix_g[plane_q], pix_b[plane_q]};
        end
        pnl_clk_d = !k_q[0] && (k_q >= KW'(2));
        if (k_q == KW'(2 * COLS + 1)) begin
          state_d = StLatch;
          k_d     = '0;
        end
      end
      StLatch: begin
        k_d = k_q + KW'(1);
        if ((k_q == '0) && (plane_q == '0)) pnl_row_d = row_q;
        if (k_q == KW'(1)) begin
          state_d = StDisplay;
          k_d     = '0;
        end
      end
      StDisplay: begin
        if (tmr_done) begin
          if (plane_q != PW'(BPC - 1)) begin
            plane_d = plane_q + PW'(1);
          end else begin
            plane_d = '0;
            if (row_q == RW'(ROWS - 1)) begin
              row_d        = '0;
              frame_done_d = 1'b1;
            end else begin
              row_d = row_q + RW'(1);
            end
          end
          k_d = '0;
          if (enable) begin
            state_d = StShift;
          end else begin
            state_d = StIdle;
            row_d   = '0;
            plane_d = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      k_q          <= '0;
      row_q        <= '0;
      plane_q      <= '0;
      led_q        <= 3'b111;
      pnl_clk_q    <= 1'b0;
      pnl_row_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      row_q        <= row_d;
      plane_q      <= plane_d;
      led_q        <= led_d;
      pnl_clk_q    <= pnl_clk_d;
      pnl_row_q    <= pnl_row_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign mem_rd_en   = (state_q == StShift) && !k_q[0] && (k_q < KW'(2 * COLS));
  assign mem_rd_addr = AW'(32'(row_q) * COLS + 32'(k_q >> 1));
  assign led_r_      = led_q[2];
  assign led_g_      = led_q[1];
  assign led_b_      = led_q[0];
  assign pnl_clk     = pnl_clk_q;
  assign pnl_lat     = (state_q == StLatch) && (k_q == '0);
  assign pnl_oe_     = (state_q != StDisplay);
  assign pnl_row     = pnl_row_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Directed bench for the LED matrix scan sequencer with default geometry (32x16, 4 planes, base 8).
module tb_led_matrix_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        mem_rd_en;
  logic [8:0]  mem_rd_addr;
  logic [11:0] mem_rd_data = 12'h000;
  logic        led_r_, led_g_, led_b_;
  logic        pnl_clk, pnl_lat, pnl_oe_;
  logic [3:0]  pnl_row;
  logic        frame_done;

  int tests = 0;
  int fails = 0;
  int rd_cnt[512];

  always #5 clk = ~clk;

  // Frame buffer: every address holds (r,g,b)=(F,0,5); zero when not read.
  always @(posedge clk) mem_rd_data <= mem_rd_en ? 12'hF05 : 12'h000;

  led_matrix_scan_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .led_r_      (led_r_),
    .led_g_      (led_g_),
    .led_b_      (led_b_),
    .pnl_clk     (pnl_clk),
    .pnl_lat     (pnl_lat),
    .pnl_oe_     (pnl_oe_),
    .pnl_row     (pnl_row),
    .frame_done  (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int bad, both, rise, nlat, run, nrun, nfd, reads, badaddr, oe_win;
    int lat_rises[4];
    int oe_run[4];
    int fd_at[2];
    logic prev_clk;

    #2 reset = 1'b1;
    #1;
    chk("rst_led_r", led_r_, 1);
    chk("rst_led_g", led_g_, 1);
    chk("rst_led_b", led_b_, 1);
    chk("rst_pnl_clk", pnl_clk, 0);
    chk("rst_pnl_lat", pnl_lat, 0);
    chk("rst_pnl_oe", pnl_oe_, 1);
    chk("rst_pnl_row", pnl_row, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_addr", mem_rd_addr, 0);
    chk("rst_frame_done", frame_done, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!pnl_oe_ || !led_r_ || !led_g_ || !led_b_ || mem_rd_en || pnl_lat) bad++;
    end
    chk("idle_quiet", bad, 0);

    // Two full frames of free-running scan; n=0 is the first SHIFT cycle.
    enable = 1'b1;
    both = 0; rise = 0; nlat = 0; run = 0; nrun = 0; nfd = 0;
    prev_clk = 1'b0;
    for (int i = 0; i < 512; i++) rd_cnt[i] = 0;
    for (int n = 0; n < 12600; n++) begin
      @(negedge clk);
      if (n == 0) begin
        chk("k0_rd_en", mem_rd_en, 1);
        chk("k0_addr", mem_rd_addr, 0);
      end
      if (n == 1) chk("k1_rd_en", mem_rd_en, 0);
      if (n == 2) begin
        chk("p0_led_r", led_r_, 0);
        chk("p0_led_g", led_g_, 1);
        chk("p0_led_b", led_b_, 0);
        chk("k2_pnl_clk", pnl_clk, 0);
        chk("k2_addr", mem_rd_addr, 1);
      end
      if (n == 3) chk("k3_pnl_clk", pnl_clk, 1);
      if (n == 64) chk("k64_rd_en", mem_rd_en, 0);
      if (n == 78) begin
        chk("p1_led_r", led_r_, 0);
        chk("p1_led_b", led_b_, 1);
      end
      if (n == 457) chk("row_before_latch", pnl_row, 0);
      if (n == 458) chk("row1_lat_pulse", pnl_lat, 1);
      if (n == 459) chk("row1_on_pnl_row", pnl_row, 1);

      if (pnl_clk && !prev_clk) rise++;
      prev_clk = pnl_clk;
      if (pnl_lat) begin
        if (nlat < 4) lat_rises[nlat] = rise;
        nlat++;
        rise = 0;
      end
      if (!pnl_oe_) run++;
      else if (run > 0) begin
        if (nrun < 4) oe_run[nrun] = run;
        nrun++;
        run = 0;
      end
      if (pnl_lat && !pnl_oe_) both++;
      if (frame_done) begin
        if (nfd < 2) fd_at[nfd] = n;
        nfd++;
      end
      if (mem_rd_en && (n < 6272)) rd_cnt[mem_rd_addr]++;
    end
    chk("shift0_clk_edges", lat_rises[0], 32);
    chk("shift1_clk_edges", lat_rises[1], 32);
    chk("oe_plane0", oe_run[0], 8);
    chk("oe_plane1", oe_run[1], 16);
    chk("oe_plane2", oe_run[2], 32);
    chk("oe_plane3", oe_run[3], 64);
    chk("lat_oe_overlap", both, 0);
    chk("frame_done_count", nfd, 2);
    chk("frame_done_first", fd_at[0], 6272);
    chk("frame_done_second", fd_at[1], 12544);
    reads = 0; badaddr = 0;
    for (int i = 0; i < 512; i++) begin
      reads += rd_cnt[i];
      if (rd_cnt[i] != 4) badaddr++;
    end
    chk("frame_reads", reads, 2048);
    chk("addr_not_read_4x", badaddr, 0);

    // Restart and drop enable during DISPLAY of row 3, plane 2 (n=1404..1435).
    enable = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    enable = 1'b1;
    oe_win = 0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      if (n == 1403) chk("r3p2_pre_oe", pnl_oe_, 1);
      if (n == 1404) chk("r3p2_first_oe", pnl_oe_, 0);
      if (n == 1435) chk("r3p2_last_oe", pnl_oe_, 0);
      if (n == 1436) begin
        chk("r3p2_idle_oe", pnl_oe_, 1);
        chk("r3p2_row", pnl_row, 3);
      end
      if ((n >= 1404) && !pnl_oe_) oe_win++;
      if ((n >= 1440) && mem_rd_en) oe_win += 1000;
      if (n == 1410) enable = 1'b0;
    end
    chk("drop_enable_oe_cycles", oe_win, 32);

    enable = 1'b1;
    for (int m = 0; m < 81; m++) begin
      @(negedge clk);
      if (m == 0) begin
        chk("restart_rd_en", mem_rd_en, 1);
        chk("restart_addr", mem_rd_addr, 0);
      end
      if (m == 66) chk("restart_lat", pnl_lat, 1);
      if (m == 67) chk("restart_row", pnl_row, 0);
    end

    // m=80 is SHIFT of plane 1, k=4: reset must clear outputs without waiting for a clock.
    chk("pre_reset_led_r", led_r_, 0);
    chk("pre_reset_rd_en", mem_rd_en, 1);
    reset = 1'b1;
    enable = 1'b0;
    #1;
    chk("async_rd_en", mem_rd_en, 0);
    chk("async_led_r", led_r_, 1);
    chk("async_led_b", led_b_, 1);
    chk("async_pnl_clk", pnl_clk, 0);
    chk("async_oe", pnl_oe_, 1);
    chk("async_addr", mem_rd_addr, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pnl_lat || !pnl_oe_ || mem_rd_en) bad++;
    end
    chk("post_reset_quiet", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
